// File: rtl/risc_pkg.sv
// Shared encodings for the RiSC-16 multicycle control path: opcodes, FSM states
// and the select codes seen by the datapath muxes.
package risc_pkg;

    localparam int unsigned InstrW   = 16;
    localparam int unsigned RegAddrW = 3;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpAddi = 3'b001,
        OpNand = 3'b010,
        OpLui  = 3'b011,
        OpSw   = 3'b100,
        OpLw   = 3'b101,
        OpBeq  = 3'b110,
        OpJalr = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        StReset,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StBranch,
        StHalt
    } state_e;

    localparam logic [1:0] Src1Rd1 = 2'd0;
    localparam logic [1:0] Src1Pc  = 2'd1;
    localparam logic [1:0] Src1Imm = 2'd2;

    localparam logic [1:0] Src2Rd2  = 2'd0;
    localparam logic [1:0] Src2Simm = 2'd1;
    localparam logic [1:0] Src2One  = 2'd2;

    localparam logic [1:0] WdAluOut = 2'd0;
    localparam logic [1:0] WdMem    = 2'd1;
    localparam logic [1:0] WdPc     = 2'd2;

    localparam logic PcAluOut = 1'b0;
    localparam logic PcRd1    = 1'b1;

    localparam logic AddrPc     = 1'b0;
    localparam logic AddrAluOut = 1'b1;

endpackage

// File: rtl/risc_decode.sv
// Combinational field extraction for a RiSC-16 instruction word.
// Immediates are consumed by the datapath straight from ir.
module risc_decode
    import risc_pkg::*;
(
    input  logic [InstrW-1:0]   ir,
    output opcode_e             opcode,
    output logic [RegAddrW-1:0] ra,
    output logic [RegAddrW-1:0] rb,
    output logic [RegAddrW-1:0] rc,
    output logic                is_halt
);

    logic [6:0] simm7;

    assign opcode = opcode_e'(ir[15:13]);
    assign ra     = ir[12:10];
    assign rb     = ir[9:7];
    assign rc     = ir[2:0];
    assign simm7  = ir[6:0];

    // JALR with a non-zero immediate field is the halt encoding
    assign is_halt = (opcode == OpJalr) && (simm7 != 7'd0);

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Multicycle control FSM for the RiSC-16 core: sequences fetch, decode, execute,
// memory and write-back, driving the datapath selects and the memory handshake.
module risc_ctrl_fsm
    import risc_pkg::*;
#(
    parameter int unsigned IW = 16,
    parameter int unsigned RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] mem_rdata,
    input  logic          mem_ready,
    input  logic          eq_in,
    output logic          mem_req,
    output logic          mem_we,
    output logic          mem_addr_sel,
    output logic          alu_add,
    output logic          alu_nand,
    output logic          alu_pass1,
    output logic          alu_eq,
    output logic [1:0]    alu_src1_sel,
    output logic [1:0]    alu_src2_sel,
    output logic          aluout_we,
    output logic [RW-1:0] rf_ra1,
    output logic [RW-1:0] rf_ra2,
    output logic [RW-1:0] rf_wa,
    output logic          rf_we,
    output logic [1:0]    rf_wd_sel,
    output logic          pc_we,
    output logic          pc_sel,
    output logic [IW-1:0] ir,
    output logic          halted
);

    state_e        state_q;
    logic [IW-1:0] ir_q;
    logic          halted_q;

    opcode_e       opcode;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;
    logic [RW-1:0] rc;
    logic          is_halt;
    logic          rf_wr_req;

    risc_decode u_decode (
        .ir      (ir_q),
        .opcode  (opcode),
        .ra      (ra),
        .rb      (rb),
        .rc      (rc),
        .is_halt (is_halt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StReset;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StReset: state_q <= StFetch;
                StFetch: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    if (is_halt) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    unique case (opcode)
                        OpAdd, OpAddi, OpNand, OpLui: state_q <= StWb;
                        OpSw, OpLw:                   state_q <= StMem;
                        OpBeq:                        state_q <= eq_in ? StBranch : StFetch;
                        OpJalr:                       state_q <= StFetch;
                    endcase
                end
                StMem: begin
                    if (mem_ready) begin
                        state_q <= StFetch;
                    end
                end
                StWb:     state_q <= StFetch;
                StBranch: state_q <= StFetch;
                StHalt:   state_q <= StHalt;
            endcase
        end
    end

    // Strobes decode from the registered state so an async reset kills them at once
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = AddrPc;
        alu_add      = 1'b0;
        alu_nand     = 1'b0;
        alu_pass1    = 1'b0;
        alu_eq       = 1'b0;
        alu_src1_sel = Src1Rd1;
        alu_src2_sel = Src2Rd2;
        aluout_we    = 1'b0;
        rf_ra1       = '0;
        rf_ra2       = '0;
        rf_wa        = '0;
        rf_wr_req    = 1'b0;
        rf_wd_sel    = WdAluOut;
        pc_we        = 1'b0;
        pc_sel       = PcAluOut;

        if (state_q inside {StDecode, StExec, StMem, StWb, StBranch}) begin
            rf_ra1 = (opcode == OpBeq) ? ra : rb;
            unique case (opcode)
                OpBeq:   rf_ra2 = rb;
                OpSw:    rf_ra2 = ra;
                default: rf_ra2 = rc;
            endcase
        end

        unique case (state_q)
            StFetch: begin
                mem_req      = 1'b1;
                mem_addr_sel = AddrPc;
                alu_add      = 1'b1;
                alu_src1_sel = Src1Pc;
                alu_src2_sel = Src2One;
                pc_we        = mem_ready;
                pc_sel       = PcAluOut;
            end
            StExec: begin
                unique case (opcode)
                    OpAdd: begin
                        alu_add   = 1'b1;
                        aluout_we = 1'b1;
                    end
                    OpAddi, OpSw, OpLw: begin
                        alu_add      = 1'b1;
                        alu_src2_sel = Src2Simm;
                        aluout_we    = 1'b1;
                    end
                    OpNand: begin
                        alu_nand  = 1'b1;
                        aluout_we = 1'b1;
                    end
                    OpLui: begin
                        alu_pass1    = 1'b1;
                        alu_src1_sel = Src1Imm;
                        aluout_we    = 1'b1;
                    end
                    OpBeq: begin
                        alu_eq = 1'b1;
                    end
                    OpJalr: begin
                        // Link and jump in one cycle; rd1 still holds the old rB if rA == rB
                        rf_wa     = ra;
                        rf_wr_req = 1'b1;
                        rf_wd_sel = WdPc;
                        pc_we     = 1'b1;
                        pc_sel    = PcRd1;
                    end
                endcase
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = AddrAluOut;
                mem_we       = (opcode == OpSw);
                if (opcode == OpLw) begin
                    rf_wa     = ra;
                    rf_wr_req = mem_ready;
                    rf_wd_sel = WdMem;
                end
            end
            StWb: begin
                rf_wa     = ra;
                rf_wr_req = 1'b1;
                rf_wd_sel = WdAluOut;
            end
            StBranch: begin
                alu_add      = 1'b1;
                alu_src1_sel = Src1Pc;
                alu_src2_sel = Src2Simm;
                pc_we        = 1'b1;
                pc_sel       = PcAluOut;
            end
            default: ;
        endcase

        // r0 is hardwired to zero
        rf_we = rf_wr_req && (rf_wa != '0);
    end

    assign ir     = ir_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Directed bench for risc_ctrl_fsm: walks hand-picked instructions through the
// FSM and compares each strobe against hand-computed values.
module tb_risc_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        eq_in;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        alu_add;
    logic        alu_nand;
    logic        alu_pass1;
    logic        alu_eq;
    logic [1:0]  alu_src1_sel;
    logic [1:0]  alu_src2_sel;
    logic        aluout_we;
    logic [2:0]  rf_ra1;
    logic [2:0]  rf_ra2;
    logic [2:0]  rf_wa;
    logic        rf_we;
    logic [1:0]  rf_wd_sel;
    logic        pc_we;
    logic        pc_sel;
    logic [15:0] ir;
    logic        halted;

    int n_checks;
    int n_errors;

    risc_ctrl_fsm #(
        .IW (16),
        .RW (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .eq_in        (eq_in),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .alu_add      (alu_add),
        .alu_nand     (alu_nand),
        .alu_pass1    (alu_pass1),
        .alu_eq       (alu_eq),
        .alu_src1_sel (alu_src1_sel),
        .alu_src2_sel (alu_src2_sel),
        .aluout_we    (aluout_we),
        .rf_ra1       (rf_ra1),
        .rf_ra2       (rf_ra2),
        .rf_wa        (rf_wa),
        .rf_we        (rf_we),
        .rf_wd_sel    (rf_wd_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .ir           (ir),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called in FETCH: present an instruction with ready and move to DECODE
    task automatic fetch(input logic [15:0] instr);
        mem_rdata = instr;
        mem_ready = 1'b1;
        #1;
        check_eq("fetch.mem_req", mem_req, 1);
        check_eq("fetch.pc_we", pc_we, 1);
        tick();
        check_eq("decode.ir", ir, instr);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        mem_rdata = 16'h0;
        mem_ready = 1'b0;
        eq_in     = 1'b0;

        // Reset state
        tick();
        tick();
        check_eq("rst.mem_req", mem_req, 0);
        check_eq("rst.alu_add", alu_add, 0);
        check_eq("rst.pc_we", pc_we, 0);
        check_eq("rst.rf_we", rf_we, 0);
        check_eq("rst.ir", ir, 16'h0000);
        check_eq("rst.halted", halted, 0);
        rst = 1'b0;
        #1;
        check_eq("reset_state.mem_req", mem_req, 0);
        tick();
        check_eq("fetch0.mem_req", mem_req, 1);
        check_eq("fetch0.alu_add", alu_add, 1);
        check_eq("fetch0.src1", alu_src1_sel, 1);
        check_eq("fetch0.src2", alu_src2_sel, 2);
        check_eq("fetch0.addr_sel", mem_addr_sel, 0);
        check_eq("fetch0.pc_we_noready", pc_we, 0);

        // ADD r1,r2,r3
        fetch(16'h0503);
        check_eq("add.dec.ra1", rf_ra1, 2);
        check_eq("add.dec.ra2", rf_ra2, 3);
        check_eq("add.dec.mem_req", mem_req, 0);
        tick();
        check_eq("add.exec.alu_add", alu_add, 1);
        check_eq("add.exec.src", {alu_src1_sel, alu_src2_sel}, 4'b0000);
        check_eq("add.exec.aluout_we", aluout_we, 1);
        check_eq("add.exec.rf_we", rf_we, 0);
        tick();
        check_eq("add.wb.rf_we", rf_we, 1);
        check_eq("add.wb.wa", rf_wa, 1);
        check_eq("add.wb.wd_sel", rf_wd_sel, 0);
        tick();
        check_eq("add.next_fetch", mem_req, 1);

        // BEQ r1,r2,+3 taken
        fetch(16'hC503);
        tick();
        eq_in = 1'b1;
        #1;
        check_eq("beq.exec.alu_eq", alu_eq, 1);
        check_eq("beq.exec.alu_add", alu_add, 0);
        check_eq("beq.exec.ra1", rf_ra1, 1);
        check_eq("beq.exec.ra2", rf_ra2, 2);
        tick();
        eq_in = 1'b0;
        check_eq("beq.br.pc_we", pc_we, 1);
        check_eq("beq.br.pc_sel", pc_sel, 0);
        check_eq("beq.br.src", {alu_src1_sel, alu_src2_sel}, 4'b0101);
        check_eq("beq.br.alu_add", alu_add, 1);
        check_eq("beq.br.mem_req", mem_req, 0);
        tick();
        check_eq("beq.after_br.mem_req", mem_req, 1);

        // BEQ not taken: straight back to FETCH
        fetch(16'hC503);
        tick();
        check_eq("beqnt.exec.alu_eq", alu_eq, 1);
        tick();
        check_eq("beqnt.fetch.mem_req", mem_req, 1);
        check_eq("beqnt.fetch.pc_sel", pc_sel, 0);

        // LW r1,r2,-1 with ready three cycles late
        fetch(16'hA57F);
        tick();
        check_eq("lw.exec.src", {alu_src1_sel, alu_src2_sel}, 4'b0001);
        check_eq("lw.exec.aluout_we", aluout_we, 1);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check_eq("lw.wait.mem_req", mem_req, 1);
            check_eq("lw.wait.addr_sel", mem_addr_sel, 1);
            check_eq("lw.wait.mem_we", mem_we, 0);
            check_eq("lw.wait.rf_we", rf_we, 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check_eq("lw.ready.rf_we", rf_we, 1);
        check_eq("lw.ready.wa", rf_wa, 1);
        check_eq("lw.ready.wd_sel", rf_wd_sel, 1);
        tick();
        check_eq("lw.next_fetch", mem_req, 1);

        // ADDI r0,r0,5: full sequence, never writes r0
        fetch(16'h2005);
        check_eq("addi.dec.rf_we", rf_we, 0);
        tick();
        check_eq("addi.exec.src2", alu_src2_sel, 1);
        check_eq("addi.exec.aluout_we", aluout_we, 1);
        check_eq("addi.exec.rf_we", rf_we, 0);
        tick();
        check_eq("addi.wb.rf_we", rf_we, 0);
        check_eq("addi.wb.mem_req", mem_req, 0);
        tick();
        check_eq("addi.next_fetch", mem_req, 1);

        // JALR r3,r3
        fetch(16'hED80);
        tick();
        check_eq("jalr.rf_we", rf_we, 1);
        check_eq("jalr.wa", rf_wa, 3);
        check_eq("jalr.wd_sel", rf_wd_sel, 2);
        check_eq("jalr.pc_we", pc_we, 1);
        check_eq("jalr.pc_sel", pc_sel, 1);
        check_eq("jalr.ra1", rf_ra1, 3);
        tick();
        check_eq("jalr.next_fetch", mem_req, 1);

        // SW r1,r2,+1 then async reset during the memory wait
        fetch(16'h8501);
        tick();
        mem_ready = 1'b0;
        tick();
        check_eq("sw.mem_req", mem_req, 1);
        check_eq("sw.mem_we", mem_we, 1);
        check_eq("sw.ra2", rf_ra2, 1);
        check_eq("sw.rf_we", rf_we, 0);
        #1;
        rst = 1'b1;
        #1;
        check_eq("sw.rst.mem_req", mem_req, 0);
        check_eq("sw.rst.mem_we", mem_we, 0);
        check_eq("sw.rst.ir", ir, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        check_eq("sw.rst.refetch", mem_req, 1);

        // Halt encoding
        fetch(16'hE001);
        check_eq("halt.dec.halted", halted, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("halt.mem_req", mem_req, 0);
            check_eq("halt.halted", halted, 1);
            check_eq("halt.pc_we", pc_we, 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
